srl_start_fifo: RTL

Synchronous FIFO built around an addressable SRL-style shift register, used for the start/done token channels between dataflow processes (e.g. in front of a `PE_*` instance). It owns the shift-register storage, the read address, occupancy and the full/empty handshakes. The producer process writes tokens and the consumer PE pops them. Storage is not reset; control state is.

---
 rtl/srl_start_fifo.sv | 119 +++++++++++
 1 files changed

// File: rtl/srl_start_fifo.sv
// srl_start_fifo: start/done token FIFO built on an addressable shift register.
// Tokens enter at SRL[0] and shift up on every accepted write; the oldest token
// sits at SRL[n-1] and is read in place (first-word-fall-through).
// Optional feature: define SRL_START_FIFO_OUT_REG_EN to add an output register
// stage in front of the consumer (capacity DEPTH+1, 2-cycle write-to-read).
module srl_start_fifo #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read,
  output logic                  if_empty_n,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic [ADDR_WIDTH:0]   if_count
);

  localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] OneCnt   = (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] srl_q [DEPTH];
  logic [ADDR_WIDTH:0]   n_q, n_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  full_n_q, full_n_d;
  logic                  empty_n_q, empty_n_d;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  push;
  logic                  pop;
  logic                  srl_pop;

  // Requests are qualified by the registered flags only, so a pop at n=DEPTH
  // never lets a write in, and a write at n=0 never lets a read in.
  assign push = if_write & full_n_q;
  assign pop  = if_read & empty_n_q;

  // Oldest entry lives at n-1; address parks at 0 when the SRL is empty.
  assign addr = (n_q == '0) ? '0 : ADDR_WIDTH'(n_q - OneCnt);

  // Shift-register storage: shift in on push, hold otherwise.
  // NOTE: storage has no reset on purpose; control state alone decides what is
  // reachable, which keeps the array mappable to SRL primitives.
  always_ff @(posedge ap_clk) begin
    if (push) begin
      srl_q[0] <= if_din;
      for (int i = 1; i < DEPTH; i++) begin
        srl_q[i] <= srl_q[i-1];
      end
    end
  end

`ifdef SRL_START_FIFO_OUT_REG_EN
  logic [DATA_WIDTH-1:0] dout_q;

  // The output register refills from the SRL whenever it is free or being
  // drained, as long as the SRL holds something.
  assign srl_pop = (n_q != '0) & (~empty_n_q | pop);
`else
  assign srl_pop = pop;
`endif

  // Next occupancy and flags for the SRL and the consumer-visible valid bit.
  // NOTE: every output gets a default first, so no path can infer a latch.
  always_comb begin
    n_d = n_q;
    case ({push, srl_pop})
      2'b10:   n_d = n_q + OneCnt;
      2'b01:   n_d = n_q - OneCnt;
      default: n_d = n_q;
    endcase
    full_n_d = (n_d != DepthCnt);
`ifdef SRL_START_FIFO_OUT_REG_EN
    empty_n_d = empty_n_q;
    if (srl_pop)  empty_n_d = 1'b1;
    else if (pop) empty_n_d = 1'b0;
    cnt_d = n_d + {{ADDR_WIDTH{1'b0}}, empty_n_d};
`else
    empty_n_d = (n_d != '0);
    cnt_d     = n_d;
`endif
  end

  // Control state: reset asynchronously so tokens vanish without a clock edge.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the pre-edge values.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      n_q       <= '0;
      cnt_q     <= '0;
      full_n_q  <= 1'b1;
      empty_n_q <= 1'b0;
    end else begin
      n_q       <= n_d;
      cnt_q     <= cnt_d;
      full_n_q  <= full_n_d;
      empty_n_q <= empty_n_d;
    end
  end

`ifdef SRL_START_FIFO_OUT_REG_EN
  // Output data register: load the oldest SRL entry on refill, else hold.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)    dout_q <= '0;
    else if (srl_pop) dout_q <= srl_q[addr];
  end

  assign if_dout = dout_q;
`else
  assign if_dout = srl_q[addr];
`endif

  assign if_full_n  = full_n_q;
  assign if_empty_n = empty_n_q;
  assign if_count   = cnt_q;

endmodule
